// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - green/yellow/red phase controller for the countdown counter
// Drives the counter's reload value and enable, and watches Count for expiry and stalls.
module traffic_phase_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic [3:0] Count,
  output logic [3:0] Mode,
  output logic       Enable,
  output logic       Green,
  output logic       Yellow,
  output logic       Red,
  output logic [1:0] Phase,
  output logic       CycleDone,
  output logic       Fault
);

  localparam logic [3:0] GREEN_LOAD  = 4'b1001;
  localparam logic [3:0] YELLOW_LOAD = 4'b0001;
  localparam logic [3:0] RED_LOAD    = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_RED,
    S_FAULT
  } state_t;

  state_t     state;
  logic       armed;
  logic [1:0] stall_cnt;
  logic [3:0] prev_count;
  logic [1:0] div;

  logic active;
  logic stalled_now;
  logic stall_trip;
  logic expired;

  assign active      = (state == S_GREEN) || (state == S_YELLOW) || (state == S_RED);
  // Enable is the registered value from the previous edge, so it gates the comparison.
  assign stalled_now = Enable && (Count == prev_count);
  assign stall_trip  = stalled_now && (stall_cnt == 2'd1);
  assign expired     = active && armed && (Count == 4'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      Mode       <= GREEN_LOAD;
      Enable     <= 1'b0;
      Green      <= 1'b0;
      Yellow     <= 1'b0;
      Red        <= 1'b1;
      Phase      <= 2'b00;
      CycleDone  <= 1'b0;
      Fault      <= 1'b0;
      armed      <= 1'b0;
      stall_cnt  <= 2'd0;
      prev_count <= 4'd0;
      div        <= 2'd0;
    end else begin
      prev_count <= Count;
      CycleDone  <= 1'b0;
      div        <= div + 2'd1;

      if (stalled_now) begin
        stall_cnt <= (stall_cnt == 2'd3) ? 2'd3 : stall_cnt + 2'd1;
      end else begin
        stall_cnt <= 2'd0;
      end

      if (active && (Count != 4'd0)) begin
        armed <= 1'b1;
      end

      if (state == S_FAULT) begin
        if (div == 2'd3) begin
          Red <= ~Red;
        end
      end else if (stall_trip) begin
        state  <= S_FAULT;
        Enable <= 1'b0;
        Green  <= 1'b0;
        Yellow <= 1'b0;
        Red    <= 1'b1;
        Phase  <= 2'b11;
        Fault  <= 1'b1;
        armed  <= 1'b0;
        div    <= 2'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (Run) begin
              state  <= S_GREEN;
              Mode   <= GREEN_LOAD;
              Enable <= 1'b1;
              Green  <= 1'b1;
              Yellow <= 1'b0;
              Red    <= 1'b0;
              Phase  <= 2'b01;
              armed  <= 1'b0;
            end
          end
          S_GREEN: begin
            if (expired) begin
              state  <= S_YELLOW;
              Mode   <= YELLOW_LOAD;
              Green  <= 1'b0;
              Yellow <= 1'b1;
              Phase  <= 2'b10;
              armed  <= 1'b0;
            end
          end
          S_YELLOW: begin
            if (expired) begin
              state  <= S_RED;
              Mode   <= RED_LOAD;
              Yellow <= 1'b0;
              Red    <= 1'b1;
              Phase  <= 2'b11;
              armed  <= 1'b0;
            end
          end
          S_RED: begin
            if (expired) begin
              CycleDone <= 1'b1;
              armed     <= 1'b0;
              Mode      <= GREEN_LOAD;
              if (Run) begin
                state  <= S_GREEN;
                Enable <= 1'b1;
                Green  <= 1'b1;
                Red    <= 1'b0;
                Phase  <= 2'b01;
              end else begin
                state  <= S_IDLE;
                Enable <= 1'b0;
                Green  <= 1'b0;
                Red    <= 1'b1;
                Phase  <= 2'b00;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
